// File: rtl/tile_result_drain_if.sv
// Read-port and output-stream bundle between the C result buffer, the drain engine and its consumer.
interface tile_result_drain_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16
);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    logic             rd_en;
    logic [AW-1:0]    rd_row;
    logic [AW-1:0]    rd_col;
    logic [ACC_W-1:0] rd_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last_tile;
    logic             m_last;

    modport master (
        output rd_en, rd_row, rd_col, m_valid, m_data, m_last_tile, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_row, rd_col, m_valid, m_data, m_last_tile, m_last,
        output rd_data, m_ready
    );
endinterface

// File: rtl/tile_result_drain.sv
// Tile-order read-out of the NxN accumulator matrix with shift/saturate and a 2-entry output FIFO.
// Define DRAIN_ROUND_EN to round half-up before the shift instead of truncating.
module tile_result_drain #(
    parameter int unsigned N     = 16,
    parameter int unsigned TILE  = 4,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] sat_count,
    tile_result_drain_if.master bus
);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int unsigned SW = ACC_W + 1;
    localparam logic signed [SW-1:0] SMAX = SW'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(longint'(1) <<< (OUT_W - 1)));
`ifdef DRAIN_ROUND_EN
    localparam logic signed [SW-1:0] RND =
        (SHIFT == 0) ? '0 : (SW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
`endif

    generate
        if (N % TILE != 0) begin : g_bad_tile
            $error("tile_result_drain: N must be a multiple of TILE");
        end
        if (SHIFT >= ACC_W) begin : g_bad_shift
            $error("tile_result_drain: SHIFT must be below ACC_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic [AW-1:0]    tr, tc;
    logic [TW-1:0]    ti, tj;
    logic [1:0]       occ;
    logic             in_flight, fl_last_tile, fl_last;
    logic [OUT_W-1:0] skid_data;
    logic             skid_last_tile, skid_last;

    logic                 pop, push, issue, elem_last_tile, elem_last;
    logic [2:0]           load;
    logic [1:0]           occ_next;
    logic signed [SW-1:0] widened, scaled;
    logic                 sat_hi, sat_lo;
    logic [OUT_W-1:0]     conv;

    // Issue decision, FIFO bookkeeping and element conversion for the returning read.
    always_comb begin
        pop            = bus.m_valid && bus.m_ready;
        push           = in_flight;
        load           = 3'(occ) + 3'(in_flight) - 3'(pop);
        issue          = (state == RUN) && (load < 3'd2);
        occ_next       = 2'(3'(occ) + 3'(push) - 3'(pop));
        elem_last_tile = (ti == TW'(TILE - 1)) && (tj == TW'(TILE - 1));
        elem_last      = elem_last_tile && (tr == AW'(N - TILE)) && (tc == AW'(N - TILE));
        widened        = {bus.rd_data[ACC_W-1], bus.rd_data};
`ifdef DRAIN_ROUND_EN
        widened        = widened + RND;
`endif
        scaled         = widened >>> SHIFT;
        sat_hi         = scaled > SMAX;
        sat_lo         = scaled < SMIN;
        conv           = sat_hi ? SMAX[OUT_W-1:0] : (sat_lo ? SMIN[OUT_W-1:0] : scaled[OUT_W-1:0]);
    end

    assign bus.rd_en  = issue;
    assign bus.rd_row = tr + AW'(ti);
    assign bus.rd_col = tc + AW'(tj);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            sat_count       <= '0;
            tr              <= '0;
            tc              <= '0;
            ti              <= '0;
            tj              <= '0;
            occ             <= '0;
            in_flight       <= 1'b0;
            fl_last_tile    <= 1'b0;
            fl_last         <= 1'b0;
            skid_data       <= '0;
            skid_last_tile  <= 1'b0;
            skid_last       <= 1'b0;
            bus.m_valid     <= 1'b0;
            bus.m_data      <= '0;
            bus.m_last_tile <= 1'b0;
            bus.m_last      <= 1'b0;
        end else begin
            done      <= 1'b0;
            in_flight <= issue;

            // Tile-order address walk: j fastest, then i, then tile column, then tile row.
            if (issue) begin
                fl_last_tile <= elem_last_tile;
                fl_last      <= elem_last;
                if (tj == TW'(TILE - 1)) begin
                    tj <= '0;
                    if (ti == TW'(TILE - 1)) begin
                        ti <= '0;
                        if (tc == AW'(N - TILE)) begin
                            tc <= '0;
                            tr <= tr + AW'(TILE);
                        end else begin
                            tc <= tc + AW'(TILE);
                        end
                    end else begin
                        ti <= ti + TW'(1);
                    end
                end else begin
                    tj <= tj + TW'(1);
                end
            end

            if (pop && occ == 2'd2) begin
                bus.m_data      <= skid_data;
                bus.m_last_tile <= skid_last_tile;
                bus.m_last      <= skid_last;
            end
            // Returning element lands in the first free slot after this cycle's pop.
            if (push) begin
                if ((occ - 2'(pop)) == 2'd0) begin
                    bus.m_data      <= conv;
                    bus.m_last_tile <= fl_last_tile;
                    bus.m_last      <= fl_last;
                end else begin
                    skid_data      <= conv;
                    skid_last_tile <= fl_last_tile;
                    skid_last      <= fl_last;
                end
            end
            occ         <= occ_next;
            bus.m_valid <= (occ_next != 2'd0);

            if (push && (sat_hi || sat_lo) && (sat_count != '1)) begin
                sat_count <= sat_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        sat_count <= '0;
                        tr        <= '0;
                        tc        <= '0;
                        ti        <= '0;
                        tj        <= '0;
                    end
                end
                RUN: begin
                    if (issue && elem_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (occ_next == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_result_drain.sv
// Scoreboard bench for tile_result_drain: expected elements queued at start, checked on each transfer.
`timescale 1ns/1ps
module tb_tile_result_drain;
    localparam int unsigned N     = 16;
    localparam int unsigned TILE  = 4;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SHIFT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] sat_count;

    tile_result_drain_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    tile_result_drain #(.N(N), .TILE(TILE), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             lt;
        logic             l;
    } exp_t;

    logic [ACC_W-1:0] mem [N][N];
    exp_t             exp_q[$];
    int               n_vec = 0;
    int               n_bad = 0;
    int               accepted = 0;
    int               issued = 0;
    int               done_cnt = 0;
    int               guard_viol = 0;
    logic [15:0]      rx_first [8];
    logic             held = 1'b0;
    exp_t             held_v;
    logic             ready_mode = 1'b0;
    logic [5:0]       pat = 6'b011001;
    int               phase = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_conv(input logic [31:0] raw, output logic sat);
        longint v;
        logic [63:0] u;
        v = longint'($signed(raw));
`ifdef DRAIN_ROUND_EN
        v = v + 128;
`endif
        v = v >>> 8;
        sat = 1'b0;
        if (v > 32767) begin
            sat = 1'b1;
            return 16'h7fff;
        end
        if (v < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        u = v;
        return u[15:0];
    endfunction

    task automatic load_expect(output int exp_sat);
        exp_t e;
        logic s;
        exp_sat = 0;
        exp_q.delete();
        for (int r0 = 0; r0 < 16; r0 += 4)
            for (int c0 = 0; c0 < 16; c0 += 4)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        e.d  = model_conv(mem[r0+i][c0+j], s);
                        e.lt = (i == 3) && (j == 3);
                        e.l  = e.lt && (r0 == 12) && (c0 == 12);
                        if (s) exp_sat++;
                        exp_q.push_back(e);
                    end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c] = 32'((r * 16 + c) << 8);
    endtask

    task automatic fill_zero();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c] = '0;
    endtask

    task automatic clear_counts();
        accepted   = 0;
        issued     = 0;
        done_cnt   = 0;
        guard_viol = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_accepted(input string tag, input int target);
        int cyc = 0;
        while (accepted < target && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        if (accepted < target) check_eq({tag, "_timeout"}, 64'(accepted), 64'(target));
    endtask

    task automatic finish_drain(input string tag, input int exp_sat);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == 0) check_eq({tag, "_done_timeout"}, 64'(done_cnt), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check_eq({tag, "_count"}, 64'(accepted), 64'(N * N));
        check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_sat_count"}, 64'(sat_count), 64'(exp_sat));
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_rd_guard"}, 64'(guard_viol), 64'd0);
    endtask

    // C buffer model: one-cycle synchronous read.
    always @(posedge clk) begin
        logic [3:0] r, c;
        if (bus.rd_en) begin
            r = bus.rd_row;
            c = bus.rd_col;
            #1 bus.rd_data = mem[r][c];
        end
    end

    // Downstream ready pattern 1,0,0,1,1,0 when enabled.
    always @(posedge clk) begin
        #1;
        if (ready_mode) begin
            bus.m_ready = pat[phase];
            phase = (phase == 5) ? 0 : phase + 1;
        end
    end

    // Output monitor: scoreboard pop, stall stability, issue guard, done pulses.
    always @(negedge clk) begin
        exp_t e;
        exp_t cur;
        int   pop_now;
        if (rst) begin
            held = 1'b0;
        end else begin
            pop_now = (bus.m_valid && bus.m_ready) ? 1 : 0;
            cur     = {bus.m_data, bus.m_last_tile, bus.m_last};
            if (bus.rd_en) begin
                if (issued - accepted - pop_now >= 2) guard_viol++;
                issued++;
            end
            if (held) begin
                check_eq("stall_valid", 64'(bus.m_valid), 64'd1);
                check_eq("stall_hold", 64'(cur), 64'(held_v));
            end
            if (pop_now == 1) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_output", 64'(accepted), 64'(N * N));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", 64'(bus.m_data), 64'(e.d));
                    check_eq("last_tile", 64'(bus.m_last_tile), 64'(e.lt));
                    check_eq("last", 64'(bus.m_last), 64'(e.l));
                end
                if (accepted < 8) rx_first[accepted] = bus.m_data;
                accepted++;
            end
            held   = bus.m_valid && !bus.m_ready;
            held_v = cur;
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sat;
        bus.m_ready = 1'b1;
        bus.rd_data = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check_eq("rst_rd_row", 64'(bus.rd_row), 64'd0);
        check_eq("rst_rd_col", 64'(bus.rd_col), 64'd0);
        check_eq("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("rst_m_data", 64'(bus.m_data), 64'd0);
        check_eq("rst_m_last_tile", 64'(bus.m_last_tile), 64'd0);
        check_eq("rst_m_last", 64'(bus.m_last), 64'd0);
        check_eq("rst_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Saturation at both rails plus an in-range value.
        fill_zero();
        mem[0][0] = 32'h7fffffff;
        mem[0][1] = 32'h80000000;
        mem[0][2] = 32'h00007fff;
        load_expect(exp_sat);
        clear_counts();
        pulse_start();
        finish_drain("sat", exp_sat);
        check_eq("sat_hi_val", 64'(rx_first[0]), 64'h7fff);
        check_eq("sat_lo_val", 64'(rx_first[1]), 64'h8000);
        check_eq("sat_mid_val", 64'(rx_first[2]), 64'h007f);
        check_eq("sat_count_two", 64'(sat_count), 64'd2);

        // Truncation versus rounding on positive and negative halves.
        fill_zero();
        mem[0][0] = 32'h00000180;
        mem[0][1] = 32'hfffffe80;
        load_expect(exp_sat);
        clear_counts();
        pulse_start();
        finish_drain("round", exp_sat);
`ifdef DRAIN_ROUND_EN
        check_eq("round_pos", 64'(rx_first[0]), 64'h0002);
        check_eq("round_neg", 64'(rx_first[1]), 64'hffff);
`else
        check_eq("round_pos", 64'(rx_first[0]), 64'h0001);
        check_eq("round_neg", 64'(rx_first[1]), 64'hfffe);
`endif

        // Full pattern, ready held high, start-to-valid latency.
        fill_pattern();
        load_expect(exp_sat);
        clear_counts();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_eq("lat_rd_en_k", 64'(bus.rd_en), 64'd1);
        check_eq("lat_valid_k", 64'(bus.m_valid), 64'd0);
        check_eq("lat_busy_k", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_eq("lat_valid_k1", 64'(bus.m_valid), 64'd0);
        @(posedge clk); #1;
        check_eq("lat_valid_k2", 64'(bus.m_valid), 64'd1);
        finish_drain("stream", exp_sat);
        check_eq("first_0", 64'(rx_first[0]), 64'd0);
        check_eq("first_3", 64'(rx_first[3]), 64'd3);
        check_eq("first_4", 64'(rx_first[4]), 64'd16);

        // Back-pressure with ready pattern.
        load_expect(exp_sat);
        clear_counts();
        phase = 0;
        ready_mode = 1'b1;
        pulse_start();
        finish_drain("stall", exp_sat);
        ready_mode = 1'b0;
        @(posedge clk); #1 bus.m_ready = 1'b1;

        // Reset 50 elements into a drain, then a fresh full drain.
        load_expect(exp_sat);
        clear_counts();
        pulse_start();
        wait_accepted("abort", 50);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check_eq("abort_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("abort_m_data", 64'(bus.m_data), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_rd_en", 64'(bus.rd_en), 64'd0);
        check_eq("abort_last", 64'({bus.m_last_tile, bus.m_last}), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        load_expect(exp_sat);
        clear_counts();
        pulse_start();
        finish_drain("restart", exp_sat);

        // Start pulse while busy must be ignored.
        load_expect(exp_sat);
        clear_counts();
        pulse_start();
        wait_accepted("restart_busy", 100);
        pulse_start();
        finish_drain("ignore_start", exp_sat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
